// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master (or decoder/mux) and the SRAM slave.
interface ahb_sram_slave_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic        hready_resp;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    input  hready_resp, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready,
    output hready_resp, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: word-organised array, programmable NONSEQ/SEQ wait
// states, byte/half/word writes, two-cycle ERROR response on illegal access.
module ahb_sram_slave #(
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned NSEQ_WAIT   = 1,
  parameter int unsigned SEQ_WAIT    = 0
) (
  input logic             hclk,
  input logic             hreset,
  ahb_sram_slave_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = 4;
  localparam logic [32:0] ADDR_LO = {1'b0, ADDR_BASE};
  localparam logic [32:0] ADDR_HI = ADDR_LO + 33'(4 * DEPTH_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               wr_q;
  logic [3:0]         strb_q;
  logic               hready_resp_q;
  logic               err_q;
  logic [31:0]        hrdata_q;

  logic [31:0]        mem_q [DEPTH_WORDS];

  logic               accept_c;
  logic               legal_c;
  logic               aligned_c;
  logic               in_range_c;
  logic [31:0]        offset_c;
  logic [IDX_W-1:0]   idx_new_c;
  logic [CNT_W-1:0]   wait_c;
  logic [3:0]         strb_new_c;
  logic [IDX_W-1:0]   rd_idx_c;
  logic [31:0]        mem_rd_c;
  logic               fwd_c;
  logic [31:0]        rd_word_c;
  logic               unused_c;

  // Address-phase decode: acceptance, legality, word index, strobes, wait load.
  always_comb begin
    accept_c   = bus.hsel & bus.hready & bus.htrans[1];
    offset_c   = bus.haddr - ADDR_BASE;
    idx_new_c  = offset_c[IDX_W+1:2];
    in_range_c = ({1'b0, bus.haddr} >= ADDR_LO) && ({1'b0, bus.haddr} < ADDR_HI);
    aligned_c  = 1'b0;
    strb_new_c = 4'b1111;
    case (bus.hsize)
      3'd0: begin
        aligned_c  = 1'b1;
        strb_new_c = 4'b0001 << bus.haddr[1:0];
      end
      3'd1: begin
        aligned_c  = ~bus.haddr[0];
        strb_new_c = bus.haddr[1] ? 4'b1100 : 4'b0011;
      end
      3'd2: begin
        aligned_c  = (bus.haddr[1:0] == 2'b00);
        strb_new_c = 4'b1111;
      end
      default: begin
        aligned_c  = 1'b0;
        strb_new_c = 4'b1111;
      end
    endcase
    legal_c = in_range_c & aligned_c;
    wait_c  = bus.htrans[0] ? CNT_W'(SEQ_WAIT) : CNT_W'(NSEQ_WAIT);
  end

  // Read word for the next LAST cycle, forwarding a write that commits at the same edge.
  always_comb begin
    rd_idx_c  = (state_q == ST_WAIT) ? idx_q : idx_new_c;
    mem_rd_c  = mem_q[rd_idx_c];
    fwd_c     = (state_q == ST_LAST) && wr_q && (idx_q == rd_idx_c);
    rd_word_c = mem_rd_c;
    for (int b = 0; b < 4; b++) begin
      if (fwd_c && strb_q[b]) begin
        rd_word_c[8*b +: 8] = bus.hwdata[8*b +: 8];
      end
    end
  end

  // Data-phase FSM with registered HREADYOUT/HRESP/HRDATA.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      wr_q          <= 1'b0;
      strb_q        <= '0;
      hready_resp_q <= 1'b1;
      err_q         <= 1'b0;
      hrdata_q      <= '0;
    end else begin
      hready_resp_q <= 1'b1;
      err_q         <= 1'b0;
      hrdata_q      <= '0;
      case (state_q)
        ST_IDLE, ST_LAST, ST_ERR2: begin
          if (accept_c) begin
            idx_q  <= idx_new_c;
            wr_q   <= bus.hwrite;
            strb_q <= strb_new_c;
            if (!legal_c) begin
              state_q       <= ST_ERR1;
              hready_resp_q <= 1'b0;
              err_q         <= 1'b1;
            end else if (wait_c == '0) begin
              state_q <= ST_LAST;
              if (!bus.hwrite) begin
                hrdata_q <= rd_word_c;
              end
            end else begin
              state_q       <= ST_WAIT;
              cnt_q         <= wait_c;
              hready_resp_q <= 1'b0;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_LAST;
            if (!wr_q) begin
              hrdata_q <= rd_word_c;
            end
          end else begin
            cnt_q         <= cnt_q - CNT_W'(1);
            hready_resp_q <= 1'b0;
          end
        end
        ST_ERR1: begin
          state_q <= ST_ERR2;
          err_q   <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Write commit at the completing edge of a legal write's LAST cycle.
  always_ff @(posedge hclk) begin
    if ((state_q == ST_LAST) && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (strb_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.hready_resp = hready_resp_q;
  assign bus.hresp       = {1'b0, err_q};
  assign bus.hrdata      = hrdata_q;

  // Burst type and the non-index address bits play no part in decode.
  assign unused_c = ^{bus.hburst, offset_c};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: single transfers, bursts, errors,
// write/read forwarding, reset abort and non-selected/idle cycles.
module tb_ahb_sram_slave;

  logic hclk;
  logic hreset;
  int   n_checks;
  int   n_errors;

  logic [31:0] wd_a   [4];
  logic [31:0] rd_a   [8];
  logic        rdy_a  [8];
  logic [1:0]  resp_a [8];
  int          npat;

  ahb_sram_slave_if bus ();

  assign bus.hready = bus.hready_resp;

  ahb_sram_slave #(
    .ADDR_BASE   (32'h0000_0000),
    .DEPTH_WORDS (256),
    .NSEQ_WAIT   (1),
    .SEQ_WAIT    (0)
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Pipelined transfer of n beats at consecutive words; records each data-phase cycle.
  task automatic xfer(input logic wr, input logic [31:0] start, input logic [2:0] size, input int n);
    int   a;
    int   d;
    logic rdy;
    bit   done;
    npat = 0;
    a    = 1;
    d    = -1;
    done = 1'b0;
    @(posedge hclk); #1;
    bus.hsel   = 1'b1;
    bus.haddr  = start;
    bus.htrans = 2'b10;
    bus.hwrite = wr;
    bus.hsize  = size;
    for (int cyc = 0; cyc < 32 && !done; cyc++) begin
      @(negedge hclk);
      rdy = bus.hready_resp;
      if (d >= 0 && npat < 8) begin
        rdy_a[npat]  = rdy;
        resp_a[npat] = bus.hresp;
        rd_a[npat]   = bus.hrdata;
        npat++;
      end
      @(posedge hclk); #1;
      if (rdy) begin
        if (d == n - 1) begin
          done = 1'b1;
        end else begin
          d++;
          bus.hwdata = wd_a[d];
          if (a < n) begin
            bus.haddr  = start + 32'(4 * a);
            bus.htrans = 2'b11;
            a++;
          end else begin
            bus.htrans = 2'b00;
            bus.hsel   = 1'b0;
          end
        end
      end
    end
    bus.htrans = 2'b00;
    bus.hsel   = 1'b0;
    if (!done) chk("xfer_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr_word(input logic [31:0] addr, input logic [31:0] data);
    wd_a[0] = data;
    xfer(1'b1, addr, 3'd2, 1);
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    xfer(1'b0, addr, 3'd2, 1);
    chk({tag, "_npat"}, 32'(npat), 32'd2);
    chk({tag, "_data"}, rd_a[1], exp);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    hreset     = 1'b1;
    bus.hsel   = 1'b0;
    bus.haddr  = '0;
    bus.htrans = 2'b00;
    bus.hwrite = 1'b0;
    bus.hsize  = 3'd2;
    bus.hburst = 3'b011;
    bus.hwdata = '0;

    // Reset state
    repeat (3) @(posedge hclk);
    @(negedge hclk);
    chk("rst_hready", 32'(bus.hready_resp), 32'd1);
    chk("rst_hresp",  32'(bus.hresp),       32'd0);
    chk("rst_hrdata", bus.hrdata,           32'd0);
    hreset = 1'b0;

    // T1: one wait state on NONSEQ write and read
    wd_a[0] = 32'hDEAD_BEEF;
    xfer(1'b1, 32'h10, 3'd2, 1);
    chk("t1_wr_npat",  32'(npat),      32'd2);
    chk("t1_wr_rdy0",  32'(rdy_a[0]),  32'd0);
    chk("t1_wr_rdy1",  32'(rdy_a[1]),  32'd1);
    chk("t1_wr_resp1", 32'(resp_a[1]), 32'd0);
    xfer(1'b0, 32'h10, 3'd2, 1);
    chk("t1_rd_rdy0",  32'(rdy_a[0]),  32'd0);
    chk("t1_rd_zero",  rd_a[0],        32'd0);
    chk("t1_rd_data",  rd_a[1],        32'hDEAD_BEEF);

    // T2: byte and half writes merge into the word
    wr_word(32'h10, 32'h1122_3344);
    wd_a[0] = 32'hA500_0000;
    xfer(1'b1, 32'h13, 3'd0, 1);
    rd_check("t2_byte", 32'h10, 32'hA522_3344);
    wd_a[0] = 32'h55AA_0000;
    xfer(1'b1, 32'h12, 3'd1, 1);
    rd_check("t2_half", 32'h10, 32'h55AA_3344);
    wd_a[0] = 32'h0000_77EE;
    xfer(1'b1, 32'h10, 3'd1, 1);
    rd_check("t2_half_lo", 32'h10, 32'h55AA_77EE);

    // T3: INCR4 write and readback, SEQ beats zero-wait
    for (int i = 0; i < 4; i++) wd_a[i] = 32'(i + 1);
    xfer(1'b1, 32'h20, 3'd2, 4);
    chk("t3_wr_npat", 32'(npat), 32'd5);
    chk("t3_wr_pat", {27'd0, rdy_a[0], rdy_a[1], rdy_a[2], rdy_a[3], rdy_a[4]}, 32'b01111);
    xfer(1'b0, 32'h20, 3'd2, 4);
    chk("t3_rd_pat", {27'd0, rdy_a[0], rdy_a[1], rdy_a[2], rdy_a[3], rdy_a[4]}, 32'b01111);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_rd_beat%0d", i), rd_a[i + 1], 32'(i + 1));

    // T4: out-of-range, misaligned and bad-size accesses give a two-cycle ERROR
    wr_word(32'h00, 32'h0102_0304);
    wd_a[0] = 32'hFFFF_FFFF;
    xfer(1'b1, 32'h400, 3'd2, 1);
    chk("t4_oor_npat",  32'(npat),      32'd2);
    chk("t4_oor_rdy0",  32'(rdy_a[0]),  32'd0);
    chk("t4_oor_resp0", 32'(resp_a[0]), 32'd1);
    chk("t4_oor_rdy1",  32'(rdy_a[1]),  32'd1);
    chk("t4_oor_resp1", 32'(resp_a[1]), 32'd1);
    xfer(1'b1, 32'h02, 3'd2, 1);
    chk("t4_mis_resp0", 32'(resp_a[0]), 32'd1);
    chk("t4_mis_rdy0",  32'(rdy_a[0]),  32'd0);
    chk("t4_mis_resp1", 32'(resp_a[1]), 32'd1);
    xfer(1'b1, 32'h01, 3'd1, 1);
    chk("t4_half_mis", 32'(resp_a[0]), 32'd1);
    xfer(1'b1, 32'h00, 3'd3, 1);
    chk("t4_size3", 32'(resp_a[0]), 32'd1);
    rd_check("t4_unchanged", 32'h00, 32'h0102_0304);
    chk("t4_ok_resp", 32'(resp_a[1]), 32'd0);

    // Write followed by a back-to-back zero-wait read of the same word
    @(posedge hclk); #1;
    bus.hsel   = 1'b1;
    bus.haddr  = 32'h40;
    bus.htrans = 2'b10;
    bus.hwrite = 1'b1;
    bus.hsize  = 3'd2;
    @(posedge hclk); #1;
    bus.hwdata = 32'hCAFE_F00D;
    bus.htrans = 2'b11;
    bus.hwrite = 1'b0;
    @(negedge hclk);
    chk("fwd_wait", 32'(bus.hready_resp), 32'd0);
    @(posedge hclk); #1;
    @(negedge hclk);
    chk("fwd_wlast", 32'(bus.hready_resp), 32'd1);
    @(posedge hclk); #1;
    bus.htrans = 2'b00;
    bus.hsel   = 1'b0;
    @(negedge hclk);
    chk("fwd_rrdy",  32'(bus.hready_resp), 32'd1);
    chk("fwd_rdata", bus.hrdata,           32'hCAFE_F00D);
    @(posedge hclk); #1;

    // T5: reset during a write's wait state aborts it
    wr_word(32'h30, 32'h0BAD_F00D);
    @(posedge hclk); #1;
    bus.hsel   = 1'b1;
    bus.haddr  = 32'h30;
    bus.htrans = 2'b10;
    bus.hwrite = 1'b1;
    bus.hsize  = 3'd2;
    @(posedge hclk); #1;
    bus.hsel   = 1'b0;
    bus.htrans = 2'b00;
    bus.hwdata = 32'h1234_5678;
    @(negedge hclk);
    chk("t5_in_wait", 32'(bus.hready_resp), 32'd0);
    #1 hreset = 1'b1;
    #1;
    chk("t5_hready", 32'(bus.hready_resp), 32'd1);
    chk("t5_hresp",  32'(bus.hresp),       32'd0);
    chk("t5_hrdata", bus.hrdata,           32'd0);
    @(posedge hclk); #1;
    hreset = 1'b0;
    rd_check("t5_kept", 32'h30, 32'h0BAD_F00D);

    // T6: IDLE, BUSY and non-selected NONSEQ are zero-wait OKAY with no effect
    @(posedge hclk); #1;
    bus.hsel   = 1'b1;
    bus.haddr  = 32'h10;
    bus.hwrite = 1'b1;
    bus.hsize  = 3'd2;
    bus.htrans = 2'b00;
    @(posedge hclk); #1;
    bus.hwdata = 32'hFFFF_FFFF;
    bus.htrans = 2'b01;
    @(negedge hclk);
    chk("t6_idle_rdy",  32'(bus.hready_resp), 32'd1);
    chk("t6_idle_resp", 32'(bus.hresp),       32'd0);
    chk("t6_idle_data", bus.hrdata,           32'd0);
    @(posedge hclk); #1;
    bus.hsel   = 1'b0;
    bus.htrans = 2'b10;
    @(negedge hclk);
    chk("t6_busy_rdy",  32'(bus.hready_resp), 32'd1);
    chk("t6_busy_data", bus.hrdata,           32'd0);
    @(posedge hclk); #1;
    bus.htrans = 2'b00;
    @(negedge hclk);
    chk("t6_nsel_rdy",  32'(bus.hready_resp), 32'd1);
    chk("t6_nsel_resp", 32'(bus.hresp),       32'd0);
    rd_check("t6_unchanged", 32'h10, 32'h55AA_77EE);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
